// File: rtl/reg_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the ARM pipeline register scoreboard.
//   REG_W      : width of an architectural register index
//   NUM_REGS   : number of architectural registers (R0..R15, R15 = PC)
//   reg_idx_t  : register index type
//   onehot_reg : register index -> one-hot NUM_REGS-bit vector
// ---------------------------------------------------------------------------
package arm_pkg;

  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;

  typedef logic [REG_W-1:0] reg_idx_t;

  function automatic logic [NUM_REGS-1:0] onehot_reg(input reg_idx_t idx);
    logic [NUM_REGS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_if
// ID-stage view of the scoreboard: the decoded instruction's write and source
// registers going in, and the stall request coming back.
//   id_valid        : ID stage holds a real instruction
//   id_wb_en        : ID instruction writes a register
//   id_dest         : ID instruction destination register
//   src1 / src2     : ID instruction source registers
//   two_src         : src2 is a real operand
//   hazard_detected : combinational stall request to IF/ID
// Modports:
//   master : ID stage (drives the instruction fields, receives the stall)
//   slave  : scoreboard
// ---------------------------------------------------------------------------
interface reg_scoreboard_if;
  import arm_pkg::*;

  logic     id_valid;
  logic     id_wb_en;
  reg_idx_t id_dest;
  reg_idx_t src1;
  reg_idx_t src2;
  logic     two_src;
  logic     hazard_detected;

  modport master (
    output id_valid, id_wb_en, id_dest, src1, src2, two_src,
    input  hazard_detected
  );

  modport slave (
    input  id_valid, id_wb_en, id_dest, src1, src2, two_src,
    output hazard_detected
  );

endinterface

// File: rtl/reg_scoreboard_track.sv
// ---------------------------------------------------------------------------
// sb_reg_track
// Pending-write tracker for a single architectural register. Holds one bit
// per pipeline stage between issue and register-file write.
//   slot_q[DEPTH-1] = write is in EXE, slot_q[0] = write is in WB.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset, clears every slot
//   shift_en : advance the pipeline by one stage (low while frozen)
//   set      : a new write to this register issues on this edge
//   busy     : a write is still far enough from WB to require a stall
// ---------------------------------------------------------------------------
module sb_reg_track #(
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic set,
  output logic busy
);

  logic [DEPTH-1:0] slot_q;
  logic [DEPTH-1:0] slot_d;

  // Each write moves one stage closer to WB; a new issue always enters at
  // EXE, so a reissue on the same edge the old write leaves WB keeps both.
  always_comb begin
    slot_d = slot_q;
    if (shift_en) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        slot_d[k] = slot_q[k + 1];
      end
      slot_d[DEPTH-1] = set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // With the WB bypass the register file is written in the first half of the
  // cycle, so an entry sitting in WB no longer blocks a reader.
  assign busy = |slot_q[DEPTH-1:WB_BYPASS];

endmodule

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Per-register pending-write tracker for the 5-stage ARM pipeline. Records
// each destination register as it issues from ID, ages it through EXE, MEM
// and WB, and requests a stall while an ID source still has a write in
// flight. Also keeps a saturating count of stall cycles.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   freeze    : global pipeline freeze, holds all state
//   flush     : ID-stage instruction is squashed (branch taken in EXE)
//   id        : ID-stage instruction fields and hazard_detected (slave)
//   busy_vec  : per-register in-flight flag (debug)
//   stall_cnt : saturating count of stall cycles
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int NUM_REGS  = 16,
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  reg_scoreboard_if.slave      id,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic [CNT_W-1:0]     stall_cnt
);
  import arm_pkg::*;

  logic                         hazard;
  logic                         issue;
  logic [arm_pkg::NUM_REGS-1:0] dest_onehot;
  logic [NUM_REGS-1:0]          busy;
  logic [CNT_W-1:0]             stall_cnt_q;
  logic [CNT_W-1:0]             stall_cnt_d;

  // The stall depends only on current state and the ID operands; freeze and
  // flush deliberately do not mask it.
  always_comb begin
    hazard = id.id_valid & (busy[id.src1] | (id.two_src & busy[id.src2]));
  end

  // A stalled, frozen or squashed instruction must not reserve its target.
  always_comb begin
    issue       = id.id_valid & id.id_wb_en & ~hazard & ~freeze & ~flush;
    dest_onehot = onehot_reg(id.id_dest);
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_track
    sb_reg_track #(
      .DEPTH     (DEPTH),
      .WB_BYPASS (WB_BYPASS)
    ) u_track (
      .clk      (clk),
      .rst      (rst),
      .shift_en (~freeze),
      .set      (issue & dest_onehot[r]),
      .busy     (busy[r])
    );
  end

  // Frozen cycles are not stalls caused by this block, so they are not
  // counted; the counter sticks at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !freeze && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id.hazard_detected = hazard;
  assign busy_vec           = busy;
  assign stall_cnt          = stall_cnt_q;

endmodule
